// File: rtl/dll_lock_supervisor_pkg.sv
// Shared definitions for the DLL lock supervisor and its status decoder.
// State encodings are fixed because they are exposed through the status register.
package dll_lock_supervisor_pkg;

    typedef enum logic [1:0] {
        ST_DLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } dll_state_e;

    localparam int unsigned STATE_W = 2;

    // Last timer value before a phase of `cycles` length expires.
    function automatic int unsigned last_tick(input int unsigned cycles);
        return (cycles == 0) ? 0 : cycles - 1;
    endfunction

endpackage

// File: rtl/dll_lock_supervisor_sat_counter.sv
// Saturating event counter with a synchronous clear that overrides the increment.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] q_o
);

    logic [CNT_W-1:0] q_q;
    logic [CNT_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (inc_i && (q_q != '1)) begin
            q_d = q_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/dll_lock_supervisor.sv
// Drives the DLL reset, qualifies LOCKED for a stable period before releasing the system
// reset, and re-resets the DLL on timeout or loss of lock while counting both events.
module dll_lock_supervisor
    import dll_lock_supervisor_pkg::*;
#(
    parameter int unsigned RST_CYC    = 8,
    parameter int unsigned TMO_CYC    = 2**20,
    parameter int unsigned STABLE_CYC = 1024,
    parameter int unsigned TMR_W      = 21,
    parameter int unsigned CNT_W      = 8
) (
    input  logic               CLKIN,
    input  logic               RST,
    input  logic               locked,
    input  logic               clr_cnt,
    output logic               dll_rst,
    output logic               sys_rst,
    output logic [STATE_W-1:0] state,
    output logic [CNT_W-1:0]   loss_cnt,
    output logic [CNT_W-1:0]   tmo_cnt
);

    localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(last_tick(RST_CYC));
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(last_tick(TMO_CYC));
    localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(last_tick(STABLE_CYC));

    logic             lk_meta_q;
    logic             lk_s_q;
    dll_state_e       state_q;
    dll_state_e       state_d;
    logic [TMR_W-1:0] tmr_q;
    logic [TMR_W-1:0] tmr_d;
    logic             dll_rst_q;
    logic             sys_rst_q;
    logic             loss_inc;
    logic             tmo_inc;

    always_ff @(posedge CLKIN) begin
        if (RST) begin
            lk_meta_q <= 1'b0;
            lk_s_q    <= 1'b0;
        end else begin
            lk_meta_q <= locked;
            lk_s_q    <= lk_meta_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        loss_inc = 1'b0;
        tmo_inc  = 1'b0;
        case (state_q)
            ST_DLL_RST: begin
                // Lock seen during the DLL reset pulse is deliberately ignored.
                if (tmr_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (lk_s_q) begin
                    state_d = ST_STABLE;
                end else if (tmr_q == TMO_LAST) begin
                    state_d = ST_DLL_RST;
                    tmo_inc = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!lk_s_q) begin
                    state_d = ST_WAIT_LOCK;
                end else if (tmr_q == STB_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!lk_s_q) begin
                    state_d  = ST_DLL_RST;
                    loss_inc = 1'b1;
                end
            end
            default: state_d = ST_DLL_RST;
        endcase
    end

    always_comb begin
        tmr_d = tmr_q + TMR_W'(1);
        if (state_d != state_q) begin
            tmr_d = '0;
        end else if (state_q == ST_RUN) begin
            tmr_d = tmr_q;
        end
    end

    // Outputs are registered from the next state so they align with state_q exactly.
    always_ff @(posedge CLKIN) begin
        if (RST) begin
            state_q   <= ST_DLL_RST;
            tmr_q     <= '0;
            dll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            dll_rst_q <= (state_d == ST_DLL_RST);
            sys_rst_q <= (state_d != ST_RUN);
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_loss_cnt (
        .clk_i(CLKIN),
        .rst_i(RST),
        .inc_i(loss_inc),
        .clr_i(clr_cnt),
        .q_o  (loss_cnt)
    );

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_tmo_cnt (
        .clk_i(CLKIN),
        .rst_i(RST),
        .inc_i(tmo_inc),
        .clr_i(clr_cnt),
        .q_o  (tmo_cnt)
    );

    assign dll_rst = dll_rst_q;
    assign sys_rst = sys_rst_q;
    assign state   = state_q;

endmodule
